i2s_rx_deser: RTL and testbench
===============================

Name: i2s_rx_deser

Overview:
- Upstream front-end of the low-pass FIR chain: deserialises an external I2S stream (slave mode; SCK/WS come from the codec) into signed parallel samples.
- Runs entirely in the i_clk domain, oversampling SCK, WS and SD.
- Emits one selected channel as a sample word plus a one-cycle strobe.
- The strobe drives the FIR's i_clk_fir sample-enable and the word drives i_samp_data.

Parameters:
- SAMP_WIDTH, 24, output sample width; MSB-first, two's complement.
- SLOT_MAX, 32, maximum legal bits per WS half-frame; longer slots are errors.
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers (≥2).

Ports:
- i_clk  input  1  system clock; must be ≥4× SCK frequency.
- i_rst_n  input  1  asynchronous active-low reset.
- i_sck  input  1  I2S bit clock, asynchronous.
- i_ws  input  1  I2S word select, asynchronous; 0 = left, 1 = right.
- i_sd  input  1  I2S serial data, asynchronous.
- i_chan_sel  input  1  channel forwarded: 0 = left, 1 = right; quasi-static.
- o_samp_data  output  SAMP_WIDTH  last completed sample of the selected channel, signed.
- o_samp_strobe  output  1  one-i_clk pulse when o_samp_data updates; connect to FIR i_clk_fir.
- o_slot_err  output  1  one-i_clk pulse when a completed slot was malformed.

Behaviour:
- Reset (async assert, sync release): o_samp_data = 0, o_samp_strobe = 0, o_slot_err = 0.
  - Synchronisers, bit counter and shift register clear.
  - FSM enters HUNT.
- Input path: i_sck, i_ws and i_sd each pass through SYNC_STAGES flops. One further register on synced SCK gives rise detection. All bit events occur only on a detected SCK rise (sck_rise = 1 for one i_clk).
- On each sck_rise, sample ws_s and sd_s. ws_edge = ws_s ≠ ws_prev; ws_prev updates on every sck_rise.
- FSM:
  - HUNT: ignore data until the first ws_edge, then go to RECV. The partial slot after reset is discarded and produces no strobe and no error.
  - RECV: bit_cnt counts bits of the current slot, starting from 0. Per sck_rise, bit_cnt < SAMP_WIDTH writes sd_s into word[SAMP_WIDTH-1-bit_cnt]; bits at index ≥ SAMP_WIDTH are ignored. bit_cnt saturates at SLOT_MAX+1.
  - I2S rule: the rise on which ws_edge is seen carries the LSB of the old slot. That bit is stored under the rule above and bit_cnt is incremented first. The slot then completes with channel = ws_prev (old value).
  - On slot completion: if channel == i_chan_sel, load o_samp_data ← word and pulse o_samp_strobe. Then clear word and bit_cnt; the next sck_rise is the MSB of the new slot.
- Short slot (final count < SAMP_WIDTH): unfilled LSBs stay 0 (left-justified). Strobe is still issued for the selected channel, and o_slot_err pulses.
- Long slot (count > SLOT_MAX): o_slot_err pulses at completion; the word is still output, holding the first SAMP_WIDTH bits.
- Error pulse applies to either channel, independent of i_chan_sel.
- Latency: o_samp_strobe and o_samp_data change together, SYNC_STAGES+2 i_clk after the first i_clk edge that samples i_sck high on the completing rise.
- Strobe spacing is ≥ 2 SCK periods; it never stays high for two consecutive i_clk.
- o_samp_data holds between strobes.
- Reset mid-slot: all state clears and the FSM returns to HUNT. No strobe is issued until a full slot is received after the next ws_edge.
- i_chan_sel change takes effect at the next slot completion; no glitch strobe.

Test Plan:
- Stereo 32-bit slots: L = 0x123456 followed by 8 zero pad bits, R = 0xABCDEF followed by 8 zero pad bits, i_chan_sel = 0, SCK = i_clk/8 → one strobe per frame with o_samp_data = 0x123456; R is never output. Set i_chan_sel = 1 → 0xABCDEF.
- Exact 24-bit slots carrying 0x800000 and 0x7FFFFF → outputs -8388608 and +8388607 exactly; o_slot_err stays 0.
- Short 16-bit slot with MSBs 0xBEEF → o_samp_data = 0xBEEF00 and o_slot_err pulses once.
- 40-bit slot → first 24 bits output and o_slot_err pulses.
- Reset released mid-slot, then a full L slot of 0x000001 → first strobe only after the complete slot, with value 0x000001; latency measured at SYNC_STAGES+2 = 4 i_clk from the SCK rise.
- Async i_rst_n asserted during RECV → all outputs read 0 within the same cycle; no strobe for the interrupted slot.

Source files
------------

// File: rtl/i2s_rx_deser.sv
// I2S slave receiver: oversamples SCK/WS/SD in i_clk, deserialises each
// WS half-frame MSB-first and forwards the selected channel as a signed word
// with a one-cycle strobe. Malformed slot lengths raise a one-cycle error.
//
// state   | meaning
// --------+---------------------------------------------------------------
// HUNT    | waiting for the first WS edge; partial slot is discarded
// RECV    | collecting bits of the current slot, completes on the WS edge
module i2s_rx_deser #(
    parameter int SAMP_WIDTH  = 24,
    parameter int SLOT_MAX    = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_sck,
    input  logic                         i_ws,
    input  logic                         i_sd,
    input  logic                         i_chan_sel,
    output logic signed [SAMP_WIDTH-1:0] o_samp_data,
    output logic                         o_samp_strobe,
    output logic                         o_slot_err
);

    localparam int CNT_W = $clog2(SLOT_MAX + 2);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SLOT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(SAMP_WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_MAX);

    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

    logic [SYNC_STAGES-1:0] sck_sync_q, ws_sync_q, sd_sync_q;
    logic                   sck_s, ws_s, sd_s, sck_rise;

    logic sck_prev_q, ws_prev_q, ws_seen_q;
    logic ev_q, sd_bit_q, edge_q, chan_q;

    logic [0:0]            state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d, cnt_inc;
    logic [SAMP_WIDTH-1:0] word_q, word_d, word_fill;
    logic                  done_d;

    logic                  done_q, done_chan_q;
    logic [SAMP_WIDTH-1:0] done_word_q;
    logic [CNT_W-1:0]      done_cnt_q;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign ws_s     = ws_sync_q[SYNC_STAGES-1];
    assign sd_s     = sd_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;

    // Synchronise the asynchronous I2S pins into i_clk.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sck_sync_q <= '0;
            ws_sync_q  <= '0;
            sd_sync_q  <= '0;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], i_sck};
            ws_sync_q  <= {ws_sync_q[SYNC_STAGES-2:0], i_ws};
            sd_sync_q  <= {sd_sync_q[SYNC_STAGES-2:0], i_sd};
        end
    end

    // Detect SCK rises and capture the WS/SD values that belong to each bit.
    // The first rise after reset only primes ws_prev so that releasing reset
    // inside a right slot does not fake a WS edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sck_prev_q <= 1'b0;
            ws_prev_q  <= 1'b0;
            ws_seen_q  <= 1'b0;
            ev_q       <= 1'b0;
            sd_bit_q   <= 1'b0;
            edge_q     <= 1'b0;
            chan_q     <= 1'b0;
        end else begin
            sck_prev_q <= sck_s;
            ev_q       <= sck_rise;
            if (sck_rise) begin
                sd_bit_q  <= sd_s;
                edge_q    <= ws_seen_q && (ws_s != ws_prev_q);
                chan_q    <= ws_prev_q;
                ws_prev_q <= ws_s;
                ws_seen_q <= 1'b1;
            end
        end
    end

    // Slot FSM next state: store the bit, count it, and close the slot on a WS edge.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        word_d    = word_q;
        done_d    = 1'b0;
        word_fill = word_q;
        cnt_inc   = (bit_cnt_q == CNT_SAT) ? bit_cnt_q : bit_cnt_q + 1'b1;
        for (int i = 0; i < SAMP_WIDTH; i++) begin
            if (bit_cnt_q == CNT_W'(SAMP_WIDTH - 1 - i)) begin
                word_fill[i] = sd_bit_q;
            end
        end
        if (ev_q) begin
            case (state_q)
                ST_HUNT: begin
                    if (edge_q) begin
                        state_d = ST_RECV;
                    end
                end
                default: begin
                    if (edge_q) begin
                        done_d    = 1'b1;
                        word_d    = '0;
                        bit_cnt_d = '0;
                    end else begin
                        word_d    = word_fill;
                        bit_cnt_d = cnt_inc;
                    end
                end
            endcase
        end
    end

    // Slot FSM state and the completed-slot hand-off register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_HUNT;
            bit_cnt_q   <= '0;
            word_q      <= '0;
            done_q      <= 1'b0;
            done_chan_q <= 1'b0;
            done_word_q <= '0;
            done_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            word_q    <= word_d;
            done_q    <= done_d;
            if (done_d) begin
                done_chan_q <= chan_q;
                done_word_q <= word_fill;
                done_cnt_q  <= cnt_inc;
            end
        end
    end

    // Output stage: forward the selected channel, flag bad slot lengths on any channel.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_samp_data   <= '0;
            o_samp_strobe <= 1'b0;
            o_slot_err    <= 1'b0;
        end else begin
            o_samp_strobe <= 1'b0;
            o_slot_err    <= 1'b0;
            if (done_q) begin
                if (done_chan_q == i_chan_sel) begin
                    o_samp_data   <= done_word_q;
                    o_samp_strobe <= 1'b1;
                end
                o_slot_err <= (done_cnt_q < CNT_MIN) || (done_cnt_q > CNT_MAX);
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_deser.sv
// Scoreboard bench for i2s_rx_deser: directed I2S slots, expected outputs queued
// at send time and popped by an independent output monitor.
module tb_i2s_rx_deser;

    localparam int SW = 24;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_sck = 1'b0;
    logic          i_ws = 1'b0;
    logic          i_sd = 1'b0;
    logic          i_chan_sel = 1'b0;
    logic [SW-1:0] o_samp_data;
    logic          o_samp_strobe;
    logic          o_slot_err;

    i2s_rx_deser #(.SAMP_WIDTH(SW), .SLOT_MAX(32), .SYNC_STAGES(2)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_sck         (i_sck),
        .i_ws          (i_ws),
        .i_sd          (i_sd),
        .i_chan_sel    (i_chan_sel),
        .o_samp_data   (o_samp_data),
        .o_samp_strobe (o_samp_strobe),
        .o_slot_err    (o_slot_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic          strobe;
        logic [SW-1:0] word;
        logic          err;
    } exp_t;

    typedef struct packed {
        logic          ws;
        logic          sel;
        logic [6:0]    nbits;
        logic [63:0]   bits;
        logic          exp_s;
        logic [SW-1:0] exp_w;
        logic          exp_e;
    } vec_t;

    exp_t          exp_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            rise_cyc = 0;
    int            last_strobe_cyc = -1;
    logic          prev_strobe = 1'b0;
    logic [SW-1:0] held_word = '0;
    vec_t          vecs [17];

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One SCK period of 8 i_clk: data changes while SCK is low, rise sampled by the DUT.
    task automatic send_bit(input logic ws, input logic sd);
        @(negedge i_clk);
        i_sck = 1'b0;
        i_ws  = ws;
        i_sd  = sd;
        repeat (3) @(negedge i_clk);
        i_sck    = 1'b1;
        rise_cyc = cyc + 1;
        repeat (4) @(negedge i_clk);
    endtask

    // WS takes the next channel's value on the last (LSB) bit, as I2S does.
    task automatic send_slot(input logic ws, input logic [63:0] bits, input int nbits,
                             input logic exp_s, input logic [SW-1:0] exp_w, input logic exp_e);
        exp_t e;
        if (exp_s || exp_e) begin
            e.strobe = exp_s;
            e.err    = exp_e;
            if (exp_s) held_word = exp_w;
            e.word   = held_word;
            exp_q.push_back(e);
        end
        for (int i = 0; i < nbits; i++) begin
            send_bit((i == nbits - 1) ? ~ws : ws, bits[6'(63 - i)]);
        end
    endtask

    // Monitor: every strobe or error pulse must match the head of the scoreboard.
    always @(negedge i_clk) begin
        if (i_rst_n && (o_samp_strobe || o_slot_err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {30'd0, o_samp_strobe, o_slot_err}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("strobe", {31'd0, o_samp_strobe}, {31'd0, e.strobe});
                check("slot_err", {31'd0, o_slot_err}, {31'd0, e.err});
                check("samp_data", {8'd0, o_samp_data}, {8'd0, e.word});
            end
            if (o_samp_strobe) begin
                check("strobe_single_cycle", {31'd0, prev_strobe}, 32'd0);
                last_strobe_cyc = cyc;
            end
        end
        prev_strobe = o_samp_strobe;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //         ws    sel   nbits  bits                      strobe word        err
        vecs[0]  = '{1'b1, 1'b0, 7'd32, 64'hABCDEF00_00000000, 1'b0, 24'h000000, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 7'd32, 64'h12345600_00000000, 1'b1, 24'h123456, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 7'd32, 64'hABCDEF00_00000000, 1'b0, 24'h000000, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 7'd32, 64'h12345600_00000000, 1'b1, 24'h123456, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 7'd32, 64'hABCDEF00_00000000, 1'b0, 24'h000000, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 7'd32, 64'h12345600_00000000, 1'b0, 24'h000000, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 7'd32, 64'hABCDEF00_00000000, 1'b1, 24'hABCDEF, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 7'd24, 64'h800000_0000000000, 1'b0, 24'h000000, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 7'd24, 64'h7FFFFF_0000000000, 1'b1, 24'h7FFFFF, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 7'd24, 64'h800000_0000000000, 1'b1, 24'h800000, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 7'd24, 64'h7FFFFF_0000000000, 1'b0, 24'h000000, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 7'd16, 64'hBEEF_000000000000, 1'b1, 24'hBEEF00, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 7'd32, 64'h13579B00_00000000, 1'b0, 24'h000000, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 7'd40, 64'hA5A5A5FFFF_000000, 1'b1, 24'hA5A5A5, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 7'd16, 64'h1234_000000000000, 1'b0, 24'h000000, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 7'd32, 64'h5A5A5A11_00000000, 1'b1, 24'h5A5A5A, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 7'd32, 64'h0F0F0F00_00000000, 1'b0, 24'h000000, 1'b0};

        repeat (5) @(negedge i_clk);
        check("reset_samp_data", {8'd0, o_samp_data}, 32'd0);
        check("reset_strobe", {31'd0, o_samp_strobe}, 32'd0);
        check("reset_slot_err", {31'd0, o_slot_err}, 32'd0);
        i_rst_n = 1'b1;

        // Partial left slot after reset, then the first WS edge.
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);

        for (int k = 0; k < 17; k++) begin
            if (vecs[k].sel != i_chan_sel) begin
                repeat (8) @(negedge i_clk);
                i_chan_sel = vecs[k].sel;
            end
            send_slot(vecs[k].ws, vecs[k].bits, int'(vecs[k].nbits),
                      vecs[k].exp_s, vecs[k].exp_w, vecs[k].exp_e);
        end
        repeat (10) @(negedge i_clk);
        check("pending_before_reset", exp_q.size(), 32'd0);

        // Reset asserted in the middle of a left slot.
        for (int i = 0; i < 10; i++) send_bit(1'b0, i[0]);
        @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        check("midrst_samp_data", {8'd0, o_samp_data}, 32'd0);
        check("midrst_strobe", {31'd0, o_samp_strobe}, 32'd0);
        check("midrst_slot_err", {31'd0, o_slot_err}, 32'd0);
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;

        // Rest of the interrupted slot is discarded, then R, then L = 0x000001.
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        send_slot(1'b1, 64'hFFFFFF00_00000000, 32, 1'b0, 24'h000000, 1'b0);
        send_slot(1'b0, 64'h00000100_00000000, 32, 1'b1, 24'h000001, 1'b0);
        repeat (10) @(negedge i_clk);
        check("strobe_latency", last_strobe_cyc - rise_cyc, 32'd4);
        check("pending_at_end", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
